bin2bcd_param: RTL and testbench
================================

# bin2bcd_param

Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It takes a WIDTH-bit binary word on a start pulse and, WIDTH+1 cycles later, presents DIGITS BCD digits with a one-cycle done strobe. It feeds the seven-segment and display paths, and it generalises the fixed 8-bit/3-digit converter to any width from 4 to 64 bits. It adds a hard reset and an optional signed mode.

## Interface
- WIDTH, 8: binary input width; legal range 4..64.
- DIGITS, derived (localparam, not overridable): (WIDTH*3)/10 + 1. This gives 3 for WIDTH 8, 5 for 16, and 10 for 32.
- clk  in  1: clock; everything is rising-edge.
- rst  in  1: reset, asynchronous, active-high.
- start  in  1: conversion request; sampled only when ready=1.
- in  in  WIDTH: binary operand; captured on the accepted start edge.
- BCD  out  4 x [DIGITS] (unpacked array): result; BCD[0] is the least significant digit.
- neg  out  1: result sign. It is driven only under the signed macro and is tied 0 otherwise.
- done  out  1: one-cycle strobe; BCD and neg are valid from this cycle on.
- ready  out  1: idle; a start is accepted on this cycle's edge.

## Operation
- FSM states:
  - IDLE: ready=1.
  - SHIFT: busy.
  - DONE: done=1, ready=0.
- IDLE with start=1 at an edge:
  - Load the shift register: binary part = operand, BCD part = 0.
  - Set the iteration counter to WIDTH and move to SHIFT.
- Each SHIFT cycle:
  - Every BCD digit >= 5 gets +3 (combinational).
  - The whole {BCD, binary} register then shifts left by 1, and the counter decrements.
- When the counter reaches 1 at a SHIFT edge, that edge does the last shift and moves to DONE.
- DONE:
  - The BCD and neg output registers are loaded on entry.
  - Hold for one cycle, then go to IDLE.
- Outputs hold their last result until the next DONE.
- start while in SHIFT or DONE: ignored, not queued.
- in may change freely after the accepted edge.
- Widths:
  - The counter is $clog2(WIDTH+1) bits.
  - The shift register is 4*DIGITS+WIDTH bits.
  - No result overflows: DIGITS covers 2^WIDTH-1 for every legal WIDTH.

## Timing
- Reset values: state IDLE, ready=1, done=0, BCD all 0, neg=0, counter 0.
- start accepted at edge k:
  - SHIFT occupies cycles k..k+WIDTH-1.
  - done=1 and BCD valid in the cycle after edge k+WIDTH.
  - ready=1 again after edge k+WIDTH+1.
- Total latency is WIDTH+1 edges from start to done. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- rst asserted mid-conversion: immediate abort with outputs at reset values. A start on the first edge after rst deasserts is accepted.
- start held high continuously: a new conversion starts each time IDLE is re-entered.

## Configuration
- BIN2BCD_SIGNED_EN defined:
  - in is two's complement.
  - The magnitude (negated if the MSB is 1) is converted.
  - neg = MSB of the captured operand.
  - The most negative value converts correctly as an unsigned WIDTH-bit magnitude.
  - Latency is unchanged, because negation happens at capture.
- BIN2BCD_SIGNED_EN not defined:
  - in is unsigned.
  - neg is constant 0, and no negation logic is present.

## Structure
- Package bin2bcd_pkg holds:
  - typedef bcd_digit_t (logic [3:0]);
  - the state enum (IDLE, SHIFT, DONE);
  - the function bcd_digits(width) that returns DIGITS.
- One natural sub-module: bcd_add3. It is a combinational single-digit corrector (>=5 -> +3) and is instantiated DIGITS times via generate.

## Test plan
- Unsigned, in=8'hFF, WIDTH=8:
  - rst, then a 1-cycle start at edge k.
  - Required: done only in the cycle after edge k+8; BCD={2,5,5} (BCD[2..0]); ready back after edge k+9.
- in=0: BCD={0,0,0}, done strobe, same latency. Also sweep all 256 inputs against an integer reference model.
- Busy rejection: start with 8'd147, then start with 8'd42 three cycles later. Required: a single done with {1,4,7}; no second done.
- WIDTH=16, in=16'hFFFF: BCD={6,5,5,3,5} (BCD[4..0]); done in the cycle after edge k+16.
- Reset abort: assert rst at edge k+4 of a conversion. Required: BCD=0, done=0 and ready=1 immediately. A start right after rst deasserts with 8'd99 yields {0,9,9}.
- Sign handling, WIDTH=8, 8'h93:
  - Under BIN2BCD_SIGNED_EN: 8'h80 gives neg=1, {1,2,8}; 8'h93 gives neg=1, {1,0,9}.
  - Without the macro: 8'h93 gives neg=0, {1,4,7}.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing helper for the parametrised binary-to-BCD converter.
package bin2bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits needed to hold 2^width-1 (valid for width 4..64).
  function automatic int unsigned bcd_digits(input int unsigned width);
    return (width * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle between a converter client (master) and bin2bcd_param (slave).
interface bin2bcd_if
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  localparam int unsigned DIGITS = bcd_digits(WIDTH);

  logic             start;
  logic [WIDTH-1:0] in;
  bcd_digit_t       BCD [DIGITS];
  logic             neg;
  logic             done;
  logic             ready;

  modport master (output start, in, input BCD, neg, done, ready);
  modport slave  (input start, in, output BCD, neg, done, ready);

endinterface

// File: rtl/bin2bcd_param_bcd_add3.sv
// Single-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q_c
);

  assign q_c = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_param.sv
// Sequential shift-and-add-3 binary-to-BCD converter, WIDTH+1 edges from start to done.
// Optional two's-complement input handling via `define BIN2BCD_SIGNED_EN.
module bin2bcd_param
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  bin2bcd_if.slave  bus
);

  localparam int unsigned DIGITS = bcd_digits(WIDTH);
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned SR_W   = BCD_W + WIDTH;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [SR_W-1:0]  sr_q, sr_n, sr_shift;
  logic [BCD_W-1:0] adj;
  logic [WIDTH-1:0] load_c;
  bcd_digit_t       bcd_q [DIGITS];
  bcd_digit_t       bcd_n [DIGITS];
  logic             done_q, done_n;
  logic             ready_q, ready_n;

  // Correct every digit, then shift the whole {BCD, binary} register by one.
  for (genvar gi = 0; gi < int'(DIGITS); gi++) begin : g_add3
    bcd_add3 u_add3 (
      .d   (sr_q[WIDTH + 4*gi +: 4]),
      .q_c (adj[4*gi +: 4])
    );
  end

  assign sr_shift = {adj, sr_q[WIDTH-1:0]} << 1;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_q, sign_n;
  logic neg_q, neg_n;

  // Negate at capture so the shift loop only ever sees a magnitude.
  assign load_c = bus.in[WIDTH-1] ? WIDTH'(-bus.in) : bus.in;
  assign bus.neg = neg_q;
`else
  assign load_c  = bus.in;
  assign bus.neg = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sr_n    = sr_q;
    bcd_n   = bcd_q;
    done_n  = 1'b0;
    ready_n = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    sign_n  = sign_q;
    neg_n   = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_n = SHIFT;
          sr_n    = SR_W'(load_c);
          cnt_n   = CNT_W'(WIDTH);
`ifdef BIN2BCD_SIGNED_EN
          sign_n  = bus.in[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        sr_n  = sr_shift;
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_n = DONE;
          for (int unsigned i = 0; i < DIGITS; i++) begin
            bcd_n[i] = sr_shift[WIDTH + 4*i +: 4];
          end
`ifdef BIN2BCD_SIGNED_EN
          neg_n = sign_q;
`endif
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    done_n  = (state_n == DONE);
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= '{default: '0};
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sr_q    <= sr_n;
      bcd_q   <= bcd_n;
      done_q  <= done_n;
      ready_q <= ready_n;
`ifdef BIN2BCD_SIGNED_EN
      sign_q  <= sign_n;
      neg_q   <= neg_n;
`endif
    end
  end

  assign bus.done  = done_q;
  assign bus.ready = ready_q;
  assign bus.BCD   = bcd_q;

endmodule

// File: tb/tb_bin2bcd_param.sv
// Scoreboard bench for bin2bcd_param at WIDTH 8 and 16; expectations follow BIN2BCD_SIGNED_EN.
module tb_bin2bcd_param;
  import bin2bcd_pkg::*;

`ifdef BIN2BCD_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct {
    logic [79:0] digs;
    logic        neg;
    int unsigned at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        q8[$];
  exp_t        q16[$];
  bit          rdy_chk8 = 1'b0;
  bit          rdy_chk16 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_if #(.WIDTH(8))  b8 ();
  bin2bcd_if #(.WIDTH(16)) b16 ();

  bin2bcd_param #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  bin2bcd_param #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [79:0] ref8(input logic [7:0] v, output logic n);
    int unsigned m = v;
    logic [79:0] r = '0;
    n = 1'b0;
    if (SGN && v[7]) begin
      m = 256 - int'(v);
      n = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Monitors: pop the oldest expectation whenever a done strobe appears.
  always @(negedge clk) begin
    logic [79:0] got;
    exp_t e;
    got = '0;
    for (int i = 0; i < 3; i++) got[4*i +: 4] = b8.BCD[i];
    if (rdy_chk8) check("ready8_after_done", 80'(b8.ready), 80'd1);
    rdy_chk8 = 1'b0;
    if (!rst && b8.done) begin
      if (q8.size() == 0) begin
        check("spurious_done8", 80'd1, 80'd0);
      end else begin
        e = q8.pop_front();
        check("bcd8", got, e.digs);
        check("neg8", 80'(b8.neg), 80'(e.neg));
        check("latency8", 80'(cyc), 80'(e.at));
        check("ready8_low_at_done", 80'(b8.ready), 80'd0);
        rdy_chk8 = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [79:0] got;
    exp_t e;
    got = '0;
    for (int i = 0; i < 5; i++) got[4*i +: 4] = b16.BCD[i];
    if (rdy_chk16) check("ready16_after_done", 80'(b16.ready), 80'd1);
    rdy_chk16 = 1'b0;
    if (!rst && b16.done) begin
      if (q16.size() == 0) begin
        check("spurious_done16", 80'd1, 80'd0);
      end else begin
        e = q16.pop_front();
        check("bcd16", got, e.digs);
        check("neg16", 80'(b16.neg), 80'(e.neg));
        check("latency16", 80'(cyc), 80'(e.at));
        rdy_chk16 = 1'b1;
      end
    end
  end

  task automatic go8(input logic [7:0] v, input logic [79:0] digs, input logic n, input bit push);
    int unsigned t = 0;
    @(negedge clk);
    while (!b8.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("timeout_ready8", 80'd0, 80'd1);
    b8.start = 1'b1;
    b8.in    = v;
    if (push) q8.push_back('{digs, n, cyc + 1 + 8});
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    b8.in    = 8'($urandom);
  endtask

  task automatic go16(input logic [15:0] v, input logic [79:0] digs, input logic n);
    int unsigned t = 0;
    @(negedge clk);
    while (!b16.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("timeout_ready16", 80'd0, 80'd1);
    b16.start = 1'b1;
    b16.in    = v;
    q16.push_back('{digs, n, cyc + 1 + 16});
    @(posedge clk);
    #1;
    b16.start = 1'b0;
    b16.in    = 16'($urandom);
  endtask

  initial begin
    logic [79:0] d;
    logic        n;
    int unsigned t;

    rst = 1'b1;
    b8.start = 1'b0;  b8.in = '0;
    b16.start = 1'b0; b16.in = '0;
    repeat (2) @(negedge clk);
    check("rst_ready8", 80'(b8.ready), 80'd1);
    check("rst_done8", 80'(b8.done), 80'd0);
    check("rst_bcd8", 80'({b8.BCD[2], b8.BCD[1], b8.BCD[0]}), 80'd0);
    check("rst_neg8", 80'(b8.neg), 80'd0);
    check("rst_ready16", 80'(b16.ready), 80'd1);
    rst = 1'b0;

    go8(8'hFF, SGN ? 80'h001 : 80'h255, SGN, 1'b1);
    go8(8'h00, 80'h000, 1'b0, 1'b1);
    go16(16'hFFFF, SGN ? 80'h00001 : 80'h65535, SGN);

    // Second start three edges into a conversion must be dropped.
    go8(8'd147, SGN ? 80'h109 : 80'h147, SGN, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    b8.start = 1'b1;
    b8.in    = 8'd42;
    @(posedge clk);
    #1;
    b8.start = 1'b0;

    go8(8'h93, SGN ? 80'h109 : 80'h147, SGN, 1'b1);
    go8(8'h80, 80'h128, SGN, 1'b1);

    // Abort mid-conversion, then restart on the first edge after release.
    go8(8'd200, 80'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    rst = 1'b1;
    #1;
    check("abort_bcd8", 80'({b8.BCD[2], b8.BCD[1], b8.BCD[0]}), 80'd0);
    check("abort_done8", 80'(b8.done), 80'd0);
    check("abort_ready8", 80'(b8.ready), 80'd1);
    @(negedge clk);
    rst = 1'b0;
    b8.start = 1'b1;
    b8.in    = 8'd99;
    q8.push_back('{80'h099, 1'b0, cyc + 1 + 8});
    @(posedge clk);
    #1;
    b8.start = 1'b0;

    for (int v = 0; v < 256; v++) begin
      d = ref8(8'(v), n);
      go8(8'(v), d, n, 1'b1);
    end

    t = 0;
    while ((q8.size() != 0 || q16.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check("drain8", 80'(q8.size()), 80'd0);
    check("drain16", 80'(q16.size()), 80'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
